// File: rtl/median_filter_frame_ctrl.sv
// Frame-synchronous enable controller and AXI4-Stream geometry monitor for the median filter.
// Optional stall watchdog is compiled in when MF_FRAME_CTRL_TIMEOUT_EN is defined.
module median_filter_frame_ctrl #(
    parameter int PX_PER_LINE     = 1920,
    parameter int LINES_PER_FRAME = 1080,
    parameter int FRAME_CNT_W     = 16,
    parameter bit EN_RESET        = 1'b1,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               en_req_i,
    input  logic                               vid_tvalid_i,
    input  logic                               vid_tready_i,
    input  logic                               vid_tuser_i,
    input  logic                               vid_tlast_i,
    input  logic                               err_clr_i,
    output logic                               en_o,
    output logic                               en_pending_o,
    output logic                               busy_o,
    output logic [$clog2(LINES_PER_FRAME)-1:0] line_cnt_o,
    output logic [FRAME_CNT_W-1:0]             frame_cnt_o,
    output logic [4:0]                         err_o
);
    localparam int                LINE_W    = $clog2(LINES_PER_FRAME);
    localparam int                PX_W      = (PX_PER_LINE > 1) ? $clog2(PX_PER_LINE) : 1;
    localparam logic [PX_W:0]     PX_FULL   = (PX_W + 1)'(PX_PER_LINE);
    localparam logic [PX_W-1:0]   PX_MAX    = PX_W'(PX_PER_LINE - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);

    typedef enum logic {
        WAIT_SOF,
        IN_FRAME
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   beat;
    logic                   en_nxt;
    logic [PX_W-1:0]        px;
    logic [PX_W-1:0]        px_nxt;
    logic [PX_W:0]          px_inc;
    logic [LINE_W-1:0]      line_nxt;
    logic [FRAME_CNT_W-1:0] frame_nxt;
    logic [4:0]             err_set;
    logic [4:0]             err_nxt;

`ifdef MF_FRAME_CTRL_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
`endif

    assign beat         = vid_tvalid_i & vid_tready_i;
    assign px_inc       = {1'b0, px} + (PX_W + 1)'(1);
    assign busy_o       = (state == IN_FRAME);
    assign en_pending_o = en_req_i ^ en_o;

    always_comb begin
        state_nxt = state;
        en_nxt    = en_o;
        px_nxt    = px;
        line_nxt  = line_cnt_o;
        frame_nxt = frame_cnt_o;
        err_set   = '0;

        case (state)
            WAIT_SOF: begin
                // The SOF cycle itself freezes the enable so the whole frame sees one value.
                if (beat && vid_tuser_i) begin
                    state_nxt = IN_FRAME;
                    px_nxt    = PX_W'(1);
                    line_nxt  = '0;
                end else begin
                    en_nxt = en_req_i;
                    if (beat) begin
                        err_set[3] = 1'b1;
                    end
                end
            end
            IN_FRAME: begin
                if (beat) begin
                    if (vid_tuser_i) begin
                        err_set[2] = 1'b1;
                        px_nxt     = PX_W'(1);
                        line_nxt   = '0;
                    end else if (vid_tlast_i) begin
                        if (px_inc < PX_FULL) begin
                            err_set[0] = 1'b1;
                        end
                        px_nxt = '0;
                        if (line_cnt_o == LINE_LAST) begin
                            frame_nxt = frame_cnt_o + FRAME_CNT_W'(1);
                            line_nxt  = '0;
                            state_nxt = WAIT_SOF;
                        end else begin
                            line_nxt = line_cnt_o + LINE_W'(1);
                        end
                    end else if (px_inc >= PX_FULL) begin
                        // Overlong line: hold at the last position until tlast arrives.
                        err_set[1] = 1'b1;
                        px_nxt     = PX_MAX;
                    end else begin
                        px_nxt = px_inc[PX_W-1:0];
                    end
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase

`ifdef MF_FRAME_CTRL_TIMEOUT_EN
        tmo_nxt = '0;
        if (state == IN_FRAME && !beat) begin
            if (tmo_cnt == TMO_LAST) begin
                err_set[4] = 1'b1;
                state_nxt  = WAIT_SOF;
                px_nxt     = '0;
                line_nxt   = '0;
            end else begin
                tmo_nxt = tmo_cnt + TMO_W'(1);
            end
        end
`else
        err_set[4] = 1'b0;
`endif

        // A bit being set in the clear cycle survives; every other bit is cleared.
        err_nxt = (err_clr_i ? 5'b0 : err_o) | err_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= WAIT_SOF;
            en_o        <= EN_RESET;
            px          <= '0;
            line_cnt_o  <= '0;
            frame_cnt_o <= '0;
            err_o       <= '0;
`ifdef MF_FRAME_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            en_o        <= en_nxt;
            px          <= px_nxt;
            line_cnt_o  <= line_nxt;
            frame_cnt_o <= frame_nxt;
            err_o       <= err_nxt;
`ifdef MF_FRAME_CTRL_TIMEOUT_EN
            tmo_cnt     <= tmo_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// Self-checking bench for median_filter_frame_ctrl: vector table applied through a scoreboard queue.
module tb_median_filter_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_req;
    logic       tvalid;
    logic       tready;
    logic       tuser;
    logic       tlast;
    logic       err_clr;
    logic       en;
    logic       en_pending;
    logic       busy;
    logic [1:0] line_cnt;
    logic [3:0] frame_cnt;
    logic [4:0] err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       req, v, r, u, l, clr;
        logic       en, pend, busy;
        logic [1:0] line;
        logic [3:0] frame;
        logic [4:0] err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    median_filter_frame_ctrl #(
        .PX_PER_LINE    (4),
        .LINES_PER_FRAME(3),
        .FRAME_CNT_W    (4),
        .EN_RESET       (1'b1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_req_i    (en_req),
        .vid_tvalid_i(tvalid),
        .vid_tready_i(tready),
        .vid_tuser_i (tuser),
        .vid_tlast_i (tlast),
        .err_clr_i   (err_clr),
        .en_o        (en),
        .en_pending_o(en_pending),
        .busy_o      (busy),
        .line_cnt_o  (line_cnt),
        .frame_cnt_o (frame_cnt),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic req, input logic v, input logic r, input logic u,
                       input logic l, input logic clr, input logic e_en, input logic e_busy,
                       input logic [1:0] e_line, input logic [3:0] e_frame, input logic [4:0] e_err);
        vec_t x;
        x.req = req; x.v = v; x.r = r; x.u = u; x.l = l; x.clr = clr;
        x.en = e_en; x.pend = req ^ e_en; x.busy = e_busy;
        x.line = e_line; x.frame = e_frame; x.err = e_err;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic req, input logic v, input logic r, input logic u,
                         input logic l, input logic clr);
        en_req = req; tvalid = v; tready = r; tuser = u; tlast = l; err_clr = clr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t x;
        vec_t e;
        logic [1:0] ln;

        // Scenario 2: clean frame, mid-frame request change must not leak into en_o.
        add(0,1,1,1,0,0, 0,1,0,0,5'h00);
        add(1,1,1,0,0,0, 0,1,0,0,5'h00);
        add(1,1,0,0,0,0, 0,1,0,0,5'h00);
        add(1,1,1,0,0,0, 0,1,0,0,5'h00);
        add(1,1,1,0,1,0, 0,1,1,0,5'h00);
        add(1,0,1,0,0,0, 0,1,1,0,5'h00);
        add(1,1,1,0,0,0, 0,1,1,0,5'h00);
        add(1,1,1,0,0,0, 0,1,1,0,5'h00);
        add(1,1,1,0,0,0, 0,1,1,0,5'h00);
        add(1,1,1,0,1,0, 0,1,2,0,5'h00);
        add(1,1,1,0,0,0, 0,1,2,0,5'h00);
        add(1,1,1,0,0,0, 0,1,2,0,5'h00);
        add(1,1,1,0,0,0, 0,1,2,0,5'h00);
        add(1,1,1,0,1,0, 0,0,0,1,5'h00);
        add(1,0,0,0,0,0, 1,0,0,1,5'h00);
        // Scenario 3: request drop in the SOF cycle is ignored; short then long line; clear.
        add(0,1,1,1,0,0, 1,1,0,1,5'h00);
        add(1,1,1,0,0,0, 1,1,0,1,5'h00);
        add(1,1,1,0,1,0, 1,1,1,1,5'h01);
        add(1,1,1,0,0,0, 1,1,1,1,5'h01);
        add(1,1,1,0,0,0, 1,1,1,1,5'h01);
        add(1,1,1,0,0,0, 1,1,1,1,5'h01);
        add(1,1,1,0,0,0, 1,1,1,1,5'h03);
        add(1,1,1,0,1,0, 1,1,2,1,5'h03);
        add(1,0,0,0,0,1, 1,1,2,1,5'h00);
        add(1,1,1,0,0,0, 1,1,2,1,5'h00);
        add(1,1,1,0,0,0, 1,1,2,1,5'h00);
        add(1,1,1,0,0,0, 1,1,2,1,5'h00);
        add(1,1,1,0,1,0, 1,0,0,2,5'h00);
        // Scenario 4: early SOF on beat 6 restarts the frame.
        add(1,1,1,1,0,0, 1,1,0,2,5'h00);
        add(1,1,1,0,0,0, 1,1,0,2,5'h00);
        add(1,1,1,0,0,0, 1,1,0,2,5'h00);
        add(1,1,1,0,1,0, 1,1,1,2,5'h00);
        add(1,1,1,0,0,0, 1,1,1,2,5'h00);
        add(1,1,1,1,0,0, 1,1,0,2,5'h04);
        for (int k = 1; k <= 11; k++) begin
            ln = (k < 3) ? 2'd0 : (k < 7) ? 2'd1 : 2'd2;
            if (k == 11) add(1,1,1,0,1,0, 1,0,0,3,5'h04);
            else         add(1,1,1,0,(k == 3 || k == 7),0, 1,1,ln,2,5'h04);
        end
        // Scenario 5: stray beat with a simultaneous clear keeps bit 3 only; then 16 frames.
        add(1,1,1,0,0,1, 1,0,0,3,5'h08);
        for (int f = 0; f < 16; f++) begin
            for (int b = 0; b < 12; b++) begin
                if (b == 11) add(1,1,1,0,1,0, 1,0,0,4'((4 + f) % 16),5'h08);
                else         add(1,1,1,(b == 0),(b % 4 == 3),0, 1,1,2'((b + 1) / 4),4'((3 + f) % 16),5'h08);
            end
        end
        // Scenario 6: stall after SOF.
        add(1,1,1,1,0,0, 1,1,0,3,5'h08);
        for (int i = 1; i <= 8; i++) begin
`ifdef MF_FRAME_CTRL_TIMEOUT_EN
            if (i == 8) add(1,0,0,0,0,0, 1,0,0,3,5'h18);
            else        add(1,0,0,0,0,0, 1,1,0,3,5'h08);
`else
            add(1,0,0,0,0,0, 1,1,0,3,5'h08);
`endif
        end
`ifdef MF_FRAME_CTRL_TIMEOUT_EN
        add(0,0,0,0,0,0, 0,0,0,3,5'h18);
`else
        add(0,0,0,0,0,0, 1,1,0,3,5'h08);
`endif

        // Scenario 1: reset behaviour and one-cycle enable latency.
        rst_n = 1'b0;
        drive(0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", en, 1);
        chk("rst_pend", en_pending, 1);
        chk("rst_busy", busy, 0);
        chk("rst_line", line_cnt, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pend", en_pending, 1);
        @(posedge clk);
        #1;
        chk("lat_en", en, 0);
        chk("lat_pend", en_pending, 0);

        foreach (tbl[i]) begin
            x = tbl[i];
            drive(x.req, x.v, x.r, x.u, x.l, x.clr);
            sb.push_back(x);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_en", i), en, e.en);
            chk($sformatf("v%0d_pend", i), en_pending, e.pend);
            chk($sformatf("v%0d_busy", i), busy, e.busy);
            chk($sformatf("v%0d_line", i), line_cnt, e.line);
            chk($sformatf("v%0d_frame", i), frame_cnt, e.frame);
            chk($sformatf("v%0d_err", i), err, e.err);
        end

        // Reset in the middle of a frame discards all progress.
        drive(1,1,1,1,0,0);
        @(posedge clk);
        #1;
        drive(1,1,1,0,0,0);
        @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        drive(0,0,0,0,0,0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_line", line_cnt, 0);
        chk("mid_rst_frame", frame_cnt, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_en", en, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
